// File: rtl/counter_tx_top.sv
// counter_tx_top: cache-event performance monitor with 8N1 UART readout.
// Eight event strobes are counted over a fixed window, the counts are packed
// into a byte FIFO as one frame per window and streamed out LSB first.
// Optional build macro HEADER_EN: each frame is prefixed with sync byte 8'hA5
// (9-byte frames instead of 8).
module counter_tx_top #(
   parameter int WINDOW       = 100,
   parameter int CNT_W        = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 217
) (
   input  logic clk,
   input  logic rstn,
   input  logic read_C_L1I,
   input  logic miss_L1I_C,
   input  logic read_C_L1D,
   input  logic write_C_L1D,
   input  logic miss_L1D_C,
   input  logic read_L1_L2,
   input  logic write_L1_L2,
   input  logic miss_L2_L1,
   output logic tx_data
);

`ifdef HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int FRAME_LEN = 8 + HDR;
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int WIN_W     = $clog2(WINDOW);
   localparam int IDX_W     = $clog2(FRAME_LEN);
   localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [AW:0]      MAX_FILL = (AW+1)'(FIFO_DEPTH - FRAME_LEN);

   typedef enum logic [0:0] {PK_IDLE, PK_WRITE} pack_state_t;
   typedef enum logic [1:0] {UX_IDLE, UX_START, UX_DATA, UX_STOP} uart_state_t;

   // Observation point for the two FSMs and the sticky drop flag; not consumed by logic.
   typedef struct packed {
      uart_state_t uart;
      pack_state_t pack;
      logic        overflow;
      logic [AW:0] fill;
   } probe_t;

   // ---------------------------------------------------------------------
   // Event counting and window snapshot
   // ---------------------------------------------------------------------
   logic [7:0]       ev;
   logic [CNT_W-1:0] cnt  [8];
   logic [CNT_W-1:0] snap [8];
   logic [WIN_W-1:0] win_cnt;
   logic             win_end;
   logic             snap_pend;

   assign ev = {miss_L2_L1, write_L1_L2, read_L1_L2, miss_L1D_C,
                write_C_L1D, read_C_L1D, miss_L1I_C, read_C_L1I};
   assign win_end = (win_cnt == WIN_W'(WINDOW - 1));

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic e);
      return (e && (c != CNT_MAX)) ? c + 1'b1 : c;
   endfunction

   // Window cycle counter: 0..WINDOW-1, wraps on the snapshot edge.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)         win_cnt <= '0;
      else if (win_end) win_cnt <= '0;
      else              win_cnt <= win_cnt + 1'b1;
   end

   // Saturating counters; the last cycle's events are folded into the snapshot
   // so nothing is lost across the window boundary.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         for (int i = 0; i < 8; i++) begin
            cnt[i]  <= '0;
            snap[i] <= '0;
         end
         snap_pend <= 1'b0;
      end else begin
         snap_pend <= win_end;
         for (int i = 0; i < 8; i++) begin
            if (win_end) begin
               snap[i] <= sat_inc(cnt[i], ev[i]);
               cnt[i]  <= '0;
            end else begin
               cnt[i]  <= sat_inc(cnt[i], ev[i]);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // FIFO handshake: the writer may assert wr_en only while !full (or while
   // a read is popping in the same cycle); the reader may assert rd_en only
   // while !empty, and rd_data is valid whenever !empty (first-word-fall-
   // through). A transfer happens on the clock edge where the strobe is high
   // and the corresponding condition holds.
   // ---------------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_count;
   logic          full, empty, wr_en, rd_en, do_wr, do_rd;
   logic [7:0]    wr_data, rd_data;

   assign full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (fifo_count == '0);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   // Storage array, no reset needed: contents are only visible via count.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Frame packer: whole frame or nothing
   // ---------------------------------------------------------------------
   pack_state_t      pk_state, pk_next;
   logic [IDX_W-1:0] pk_idx, pk_idx_next;
   logic             overflow, overflow_next;
   logic             space_ok;

   assign space_ok = (fifo_count <= MAX_FILL);

   // Packer state register and sticky overflow flag.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         pk_state <= PK_IDLE;
         pk_idx   <= '0;
         overflow <= 1'b0;
      end else begin
         pk_state <= pk_next;
         pk_idx   <= pk_idx_next;
         overflow <= overflow_next;
      end
   end

   // Packer next state: on a snapshot, either commit the full frame or drop it.
   always_comb begin
      pk_next       = pk_state;
      pk_idx_next   = pk_idx;
      overflow_next = overflow;
      wr_en         = 1'b0;
      case (pk_state)
         PK_IDLE: begin
            if (snap_pend) begin
               if (space_ok) begin
                  pk_next     = PK_WRITE;
                  pk_idx_next = '0;
               end else begin
                  overflow_next = 1'b1;
               end
            end
         end
         PK_WRITE: begin
            wr_en = 1'b1;
            if (pk_idx == IDX_W'(FRAME_LEN - 1)) pk_next = PK_IDLE;
            else                                 pk_idx_next = pk_idx + 1'b1;
         end
         default: pk_next = PK_IDLE;
      endcase
   end

   // Frame byte select: optional sync byte, then events 0..7.
   always_comb begin
      wr_data = 8'h00;
`ifdef HEADER_EN
      if (pk_idx == '0) wr_data = 8'hA5;
      else              wr_data = 8'(snap[3'(pk_idx - 1'b1)]);
`else
      wr_data = 8'(snap[pk_idx]);
`endif
   end

   // ---------------------------------------------------------------------
   // UART transmitter (8N1, LSB first)
   // ---------------------------------------------------------------------
   uart_state_t       ux_state, ux_next;
   logic [BAUD_W-1:0] baud_cnt, baud_next;
   logic [2:0]        bit_idx, bit_next;
   logic [7:0]        sh_reg, sh_next;
   logic              tx_next;
   logic              baud_tick;

   assign baud_tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

   // UART state register; tx_data is registered so the line never glitches.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         ux_state <= UX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         sh_reg   <= '0;
         tx_data  <= 1'b1;
      end else begin
         ux_state <= ux_next;
         baud_cnt <= baud_next;
         bit_idx  <= bit_next;
         sh_reg   <= sh_next;
         tx_data  <= tx_next;
      end
   end

   // UART next state; pops a byte when leaving IDLE or at the end of STOP.
   always_comb begin
      ux_next   = ux_state;
      baud_next = baud_cnt;
      bit_next  = bit_idx;
      sh_next   = sh_reg;
      rd_en     = 1'b0;
      tx_next   = 1'b1;
      case (ux_state)
         UX_IDLE: begin
            if (!empty) begin
               rd_en     = 1'b1;
               sh_next   = rd_data;
               baud_next = '0;
               ux_next   = UX_START;
            end
         end
         UX_START: begin
            if (baud_tick) begin
               baud_next = '0;
               bit_next  = '0;
               ux_next   = UX_DATA;
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         UX_DATA: begin
            if (baud_tick) begin
               baud_next = '0;
               if (bit_idx == 3'd7) begin
                  ux_next = UX_STOP;
               end else begin
                  bit_next = bit_idx + 1'b1;
                  sh_next  = {1'b0, sh_reg[7:1]};
               end
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         UX_STOP: begin
            if (baud_tick) begin
               baud_next = '0;
               if (!empty) begin
                  rd_en   = 1'b1;
                  sh_next = rd_data;
                  ux_next = UX_START;
               end else begin
                  ux_next = UX_IDLE;
               end
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         default: ux_next = UX_IDLE;
      endcase
      case (ux_next)
         UX_START: tx_next = 1'b0;
         UX_DATA:  tx_next = sh_next[0];
         default:  tx_next = 1'b1;
      endcase
   end

   probe_t probe_unused;
   assign probe_unused = '{uart: ux_state, pack: pk_state, overflow: overflow, fill: fifo_count};

endmodule

// File: tb/tb_counter_tx_top.sv
// tb_counter_tx_top: randomized stimulus against a window-count reference
// model; two instances (8-bit and 4-bit counters) share the event inputs and
// their UART lines are decoded back into frames for the scoreboard.
module tb_counter_tx_top;
   localparam int WINDOW = 100;
   localparam int CPB    = 4;
`ifdef HEADER_EN
   localparam int FRAME_LEN = 9;
`else
   localparam int FRAME_LEN = 8;
`endif
   localparam int FB = FRAME_LEN * 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] ev = '0;
   logic       tx_a, tx_b;

   counter_tx_top #(.WINDOW(WINDOW), .CNT_W(8), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rstn(rst),
      .read_C_L1I(ev[0]), .miss_L1I_C(ev[1]), .read_C_L1D(ev[2]), .write_C_L1D(ev[3]),
      .miss_L1D_C(ev[4]), .read_L1_L2(ev[5]), .write_L1_L2(ev[6]), .miss_L2_L1(ev[7]),
      .tx_data(tx_a));

   counter_tx_top #(.WINDOW(WINDOW), .CNT_W(4), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB)) dut_sat (
      .clk(clk), .rstn(rst),
      .read_C_L1I(ev[0]), .miss_L1I_C(ev[1]), .read_C_L1D(ev[2]), .write_C_L1D(ev[3]),
      .miss_L1D_C(ev[4]), .read_L1_L2(ev[5]), .write_L1_L2(ev[6]), .miss_L2_L1(ev[7]),
      .tx_data(tx_b));

   // ---------------- model and scoreboard state ----------------
   int              cur [8];
   int              edge_n, win_idx;
   logic [FB-1:0]   exp_q   [2][$];
   int              exp_win [2][$];
   int              frames_seen [2];
   int              n_checks = 0;
   int              n_pass   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   function automatic logic tx_of(input int which);
      return (which != 0) ? tx_b : tx_a;
   endfunction

   // Expected frame for the current window: each count clipped at maxv.
   function automatic logic [FB-1:0] build_frame(input int maxv);
      logic [FB-1:0] fr;
      fr = '0;
`ifdef HEADER_EN
      fr = FB'(8'hA5);
`endif
      for (int i = 0; i < 8; i++) fr = (fr << 8) | FB'((cur[i] < maxv) ? cur[i] : maxv);
      return fr;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) cur[i] = 0;
      edge_n  = 0;
      win_idx = 0;
      for (int k = 0; k < 2; k++) begin
         exp_q[k].delete();
         exp_win[k].delete();
         frames_seen[k] = 0;
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge: drives events for the next rising edge.
   task automatic step(input logic [7:0] e);
      ev = e;
      for (int i = 0; i < 8; i++) if (e[i]) cur[i]++;
      edge_n++;
      if (edge_n == WINDOW) begin
         exp_q[0].push_back(build_frame(255));
         exp_win[0].push_back(win_idx);
         exp_q[1].push_back(build_frame(15));
         exp_win[1].push_back(win_idx);
         win_idx++;
         edge_n = 0;
         for (int i = 0; i < 8; i++) cur[i] = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      #1;
      rst = 1'b1;
      ev  = '0;
      model_clear();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("reset_tx_a", tx_a, 1'b1);
         chk("reset_tx_b", tx_b, 1'b1);
      end
      chk("reset_overflow", dut.overflow, 1'b0);
      rst = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int c;
      c = 0;
      while ((frames_seen[0] < n || frames_seen[1] < n) && c < 3000) begin
         step(8'h00);
         c++;
      end
      chk("frame_wait_timeout", (frames_seen[0] >= n) && (frames_seen[1] >= n), 1'b1);
   endtask

   // ---------------- UART decoder / scoreboard ----------------
   task automatic wait_n(input int n, output bit ab);
      ab = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rst) begin
            ab = 1'b1;
            return;
         end
      end
   endtask

   task automatic rx_byte(input int which, output logic [7:0] b, output bit ok);
      bit ab;
      b  = '0;
      ok = 1'b0;
      wait_n(CPB / 2, ab);
      if (ab) return;
      chk("start_bit", tx_of(which), 1'b0);
      for (int j = 0; j < 8; j++) begin
         wait_n(CPB, ab);
         if (ab) return;
         b[j] = tx_of(which);
      end
      wait_n(CPB, ab);
      if (ab) return;
      chk("stop_bit", tx_of(which), 1'b1);
      ok = 1'b1;
   endtask

   // Matches a received frame against the oldest outstanding window whose
   // contents agree; windows skipped over are frames the design dropped.
   task automatic check_frame(input int which, input logic [FB-1:0] got);
      logic [FB-1:0] expv;
      int            w;
      bit            found;
      found = 1'b0;
      w     = -1;
      expv  = '0;
      if (exp_q[which].size() > 0) expv = exp_q[which][0];
      while (!found && exp_q[which].size() > 0) begin
         if (exp_q[which][0] === got) begin
            found = 1'b1;
            expv  = exp_q[which][0];
            w     = exp_win[which][0];
         end
         void'(exp_q[which].pop_front());
         void'(exp_win[which].pop_front());
      end
      chk((which != 0) ? "frame_sat" : "frame", {found, got}, {1'b1, expv});
      // The first two windows after reset always fit in the FIFO.
      if (frames_seen[which] < 2) chk("frame_order", w, frames_seen[which]);
      frames_seen[which]++;
   endtask

   task automatic rx_loop(input int which);
      logic [FB-1:0] fr;
      logic [7:0]    b;
      int            nb;
      bit            ok;
      fr = '0;
      nb = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            fr = '0;
            nb = 0;
         end else if (tx_of(which) === 1'b0) begin
            rx_byte(which, b, ok);
            if (!ok) begin
               fr = '0;
               nb = 0;
            end else begin
               fr = {fr[FB-9:0], b};
               nb++;
               if (nb == FRAME_LEN) begin
                  check_frame(which, fr);
                  fr = '0;
                  nb = 0;
               end
            end
         end
      end
   endtask

   initial rx_loop(0);
   initial rx_loop(1);

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] mask;
      bit         seen;
      int         t1;
      model_clear();

      // Idle reset, an empty window, then five read_C_L1I cycles in window 1.
      do_reset(5);
      for (int c = 0; c < WINDOW; c++) step(8'h00);
      t1 = $urandom_range(0, WINDOW - 5);
      for (int c = 0; c < WINDOW; c++) step((c >= t1 && c < t1 + 5) ? 8'h01 : 8'h00);
      wait_frames(2);

      // Events 2,4,5 held 250 cycles (100,100,50; 4-bit copy saturates at 15),
      // then randomly masked random traffic that outruns the UART.
      do_reset(5);
      for (int c = 0; c < 250; c++) step(8'h34);
      for (int w = 0; w < 8; w++) begin
         mask = 8'($urandom_range(0, 255));
         for (int c = 0; c < WINDOW; c++) step(8'($urandom_range(0, 255)) & mask);
      end
      chk("overflow_sticky", dut.overflow, 1'b1);
      chk("overflow_sticky_sat", dut_sat.overflow, 1'b1);
      chk("frames_received", frames_seen[0] >= 2, 1'b1);

      // Reset in the middle of a byte: the line must go high immediately.
      seen = 1'b0;
      for (int c = 0; c < 2000 && !seen; c++) begin
         step(8'($urandom_range(0, 255)));
         if (tx_a === 1'b0) seen = 1'b1;
      end
      chk("tx_low_before_reset", seen, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("async_reset_tx_a", tx_a, 1'b1);
      chk("async_reset_tx_b", tx_b, 1'b1);
      do_reset(5);

      // Fresh start after reset: random window 0 must arrive intact.
      for (int c = 0; c < WINDOW; c++) step(8'($urandom_range(0, 255)));
      wait_frames(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
